serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor: DIFF = A - B, computed LSB-first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_full_adder.sv | 14 +
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the control FSM state encoding used by the top level.
package serial_subtractor_pkg;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_adder.sv
// Single-bit full adder cell used by the serial datapath.
// Combinational only; the caller registers the carry.
module serial_subtractor_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_c,
    output logic cout_c
);

    assign s_c    = a_i ^ b_i ^ cin_i;
    assign cout_c = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule : serial_subtractor_full_adder

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b, one bit per clock, LSB first.
// One full-adder cell computes a + ~b + 1 with start/busy/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         cout,
    output logic         overflow,
    output logic         zero
);

    localparam int unsigned CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     a_sh_q, a_sh_d;
    logic [N-1:0]     nb_sh_q, nb_sh_d;
    logic [N-2:0]     res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N-1:0]     diff_q, diff_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             sum_c;
    logic             carry_out_c;
    logic [N-1:0]     res_full_c;

    serial_subtractor_full_adder u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (nb_sh_q[0]),
        .cin_i  (carry_q),
        .s_c    (sum_c),
        .cout_c (carry_out_c)
    );

    // Partial result keeps N-1 bits; the current sum bit completes it on the last edge.
    assign res_full_c = {sum_c, res_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        nb_sh_d = nb_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = a;
                    nb_sh_d = ~b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    a_msb_d = a[N-1];
                    b_msb_d = b[N-1];
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d   = res_full_c[N-1:1];
                a_sh_d  = {1'b0, a_sh_q[N-1:1]};
                nb_sh_d = {1'b0, nb_sh_q[N-1:1]};
                carry_d = carry_out_c;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    diff_d  = res_full_c;
                    cout_d  = carry_out_c;
                    ovf_d   = (a_msb_q != b_msb_q) && (sum_c != a_msb_q);
                    zero_d  = ~|res_full_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            nb_sh_q <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            nb_sh_q <= nb_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at N=8: directed vectors,
// multi-cycle corner sequences and random operands against an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy, done, cout, overflow, zero;
    logic [N-1:0] diff;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N-1:0] av;
        logic [N-1:0] bv;
        logic [N-1:0] exp_diff;
        logic         exp_cout;
        logic         exp_ovf;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[5];

    serial_subtractor #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Two's-complement subtraction from integer arithmetic.
    function automatic void model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                  output logic [N-1:0] d, output logic c,
                                  output logic o, output logic z);
        int ud;
        int sd;
        ud = int'(av) - int'(bv);
        sd = int'($signed(av)) - int'($signed(bv));
        d  = N'(ud);
        c  = (av >= bv);
        o  = (sd > 127) || (sd < -128);
        z  = (d == '0);
    endfunction

    task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen, or after the cycle budget.
    task automatic wait_done(output int busy_cycles, output logic seen);
        int guard;
        busy_cycles = 0;
        seen = 1'b0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) busy_cycles++;
            guard++;
            @(negedge clk);
        end
        seen = done;
    endtask

    task automatic check_result(input string tag, input logic [N-1:0] ed,
                                input logic ec, input logic eo, input logic ez);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"},  32'(overflow), 32'(eo));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
    endtask

    initial begin
        int           bc;
        logic         seen;
        logic [N-1:0] ed, ra, rb;
        logic         ec, eo, ez, spurious;

        vecs[0] = '{8'd5,  8'd3,  8'h02, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'd3,  8'd5,  8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h2A, 8'h2A, 8'h00, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check_result("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Directed vectors
        foreach (vecs[i]) begin
            launch(vecs[i].av, vecs[i].bv);
            wait_done(bc, seen);
            check("vec_done_seen", 32'(seen), 32'd1);
            check("vec_busy_cycles", 32'(bc), 32'd8);
            check_result("vec", vecs[i].exp_diff, vecs[i].exp_cout,
                         vecs[i].exp_ovf, vecs[i].exp_zero);
            @(negedge clk);
            check("vec_done_pulse", 32'(done), 32'd0);
        end

        // Start held through RUN with operands churning: exactly one operation
        @(negedge clk);
        a = 8'h2A;
        b = 8'h2A;
        start = 1'b1;
        @(negedge clk);
        a = 8'hC3;
        b = 8'h11;
        wait_done(bc, seen);
        start = 1'b0;
        check("hold_done_seen", 32'(seen), 32'd1);
        check("hold_busy_cycles", 32'(bc), 32'd8);
        check_result("hold", 8'h00, 1'b1, 1'b0, 1'b1);
        spurious = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) spurious = 1'b1;
        end
        check("hold_single_op", 32'(spurious), 32'd0);

        // Reset mid-RUN after a result is already on the outputs
        launch(8'd5, 8'd3);
        wait_done(bc, seen);
        check("pre_rst_diff", 32'(diff), 32'h02);
        launch(8'h55, 8'h22);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        spurious = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) spurious = 1'b1;
        end
        check("rst_no_done", 32'(spurious), 32'd0);
        launch(8'h10, 8'h01);
        wait_done(bc, seen);
        check("post_rst_seen", 32'(seen), 32'd1);
        check_result("post_rst", 8'h0F, 1'b1, 1'b0, 1'b0);

        // Back-to-back: new start in the DONE cycle, old result held until next done
        launch(8'h40, 8'h11);
        wait_done(bc, seen);
        check("b2b_first_diff", 32'(diff), 32'h2F);
        a = 8'h09;
        b = 8'h04;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        for (int g = 0; g < 40 && !done; g++) begin
            if (busy) bc++;
            check("b2b_held_diff", 32'(diff), 32'h2F);
            @(negedge clk);
        end
        check("b2b_done_seen", 32'(done), 32'd1);
        check("b2b_busy_cycles", 32'(bc), 32'd8);
        check_result("b2b", 8'h05, 1'b1, 1'b0, 1'b0);

        // Random operands against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            ra = N'($urandom);
            rb = (k % 8 == 0) ? ra : N'($urandom);
            model(ra, rb, ed, ec, eo, ez);
            launch(ra, rb);
            wait_done(bc, seen);
            check("rnd_done_seen", 32'(seen), 32'd1);
            check_result("rnd", ed, ec, eo, ez);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_serial_subtractor
